// File: rtl/led_pwm_fader.sv
// led_pwm_fader: output stage for the 6-LED binary counter. Each LED fades
// linearly between dark and full brightness using per-LED PWM instead of
// switching hard on/off.
//
// Ports:
//   CLK        system clock (27 MHz board clock)
//   RESETn     asynchronous, active-low reset
//   i_pattern  target pattern, active-high (1 = LED should be lit)
//   i_en       1 = normal operation, 0 = all LEDs forced dark
//   o_led      active-low PWM LED drive (0 = LED lit), registered
//   o_busy     1 while any LED level differs from its target, registered
module led_pwm_fader #(
  parameter int unsigned PWM_BITS         = 8,
  parameter int unsigned FADE_STEP_CYCLES = 52_734
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [5:0] i_pattern,
  input  logic       i_en,
  output logic [5:0] o_led,
  output logic       o_busy
);

  localparam int unsigned NUM_LEDS = 6;
  localparam int unsigned PRE_W    = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] LVL_ZERO = '0;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_STEP_CYCLES - 1);

  // Per-LED ramp state, derived each cycle from level and target.
  typedef enum logic [1:0] {
    LED_OFF,
    LED_RISING,
    LED_ON,
    LED_FALLING
  } led_state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] lvl_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] pat_q;

  logic [PRE_W-1:0]    prescaler_d;
  logic [PWM_BITS-1:0] lvl_d [NUM_LEDS];
  logic [PWM_BITS-1:0] tgt   [NUM_LEDS];
  led_state_t          led_state [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit_d;
  logic                busy_d;
  logic                step_tick;

  // State registers: counters, levels, input pattern and output drive.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pwm_cnt   <= '0;
      prescaler <= '0;
      pat_q     <= '0;
      o_led     <= '1;
      o_busy    <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        lvl_q[i] <= '0;
      end
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      prescaler <= prescaler_d;
      pat_q     <= i_pattern;
      o_led     <= ~lit_d;
      o_busy    <= busy_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  // Next-state: prescaler, per-LED ramp step, PWM compare and busy flag.
  always_comb begin
    step_tick   = (prescaler == PRE_LAST);
    prescaler_d = step_tick ? '0 : prescaler + 1'b1;
    lit_d       = '0;
    busy_d      = 1'b0;

    for (int i = 0; i < NUM_LEDS; i++) begin
      tgt[i]       = pat_q[i] ? LVL_MAX : LVL_ZERO;
      lvl_d[i]     = lvl_q[i];
      led_state[i] = LED_OFF;

      if (lvl_q[i] < tgt[i]) begin
        led_state[i] = LED_RISING;
      end else if (lvl_q[i] > tgt[i]) begin
        led_state[i] = LED_FALLING;
      end else if (lvl_q[i] == LVL_MAX) begin
        led_state[i] = LED_ON;
      end

      // RISING/FALLING imply lvl is strictly inside the range it moves toward,
      // so +1/-1 can never wrap.
      if (step_tick) begin
        case (led_state[i])
          LED_RISING:  lvl_d[i] = lvl_q[i] + 1'b1;
          LED_FALLING: lvl_d[i] = lvl_q[i] - 1'b1;
          default:     lvl_d[i] = lvl_q[i];
        endcase
      end

      // Full level is forced fully on; otherwise lit for lvl clocks per period.
      lit_d[i] = (lvl_q[i] == LVL_MAX) || (lvl_q[i] > pwm_cnt);
      busy_d   = busy_d || (lvl_q[i] != tgt[i]);
    end

    // Disable wins over any step: dark outputs, levels and prescaler cleared.
    if (!i_en) begin
      prescaler_d = '0;
      lit_d       = '0;
      busy_d      = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        lvl_d[i] = '0;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
module tb_led_pwm_fader;

  localparam int unsigned PB     = 4;
  localparam int unsigned FSC    = 4;
  localparam int          MAXV   = 15;
  localparam int          PERIOD = 16;

  logic       CLK       = 1'b0;
  logic       RESETn    = 1'b1;
  logic [5:0] i_pattern = '0;
  logic       i_en      = 1'b0;
  logic [5:0] o_led;
  logic       o_busy;

  // Second instance with a slow step so a mid-level can be held for duty measurement.
  logic       rst2_n = 1'b1;
  logic [5:0] pat2   = '0;
  logic [5:0] o_led2;
  logic       busy2;

  led_pwm_fader #(.PWM_BITS(PB), .FADE_STEP_CYCLES(FSC)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .i_pattern (i_pattern),
    .i_en      (i_en),
    .o_led     (o_led),
    .o_busy    (o_busy)
  );

  led_pwm_fader #(.PWM_BITS(PB), .FADE_STEP_CYCLES(1000)) dut_slow (
    .CLK       (CLK),
    .RESETn    (rst2_n),
    .i_pattern (pat2),
    .i_en      (1'b1),
    .o_led     (o_led2),
    .o_busy    (busy2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] led;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  int         m_pwm;
  int         m_pre;
  int         m_lvl [6];
  logic [5:0] m_pat;
  logic [5:0] m_led;
  logic       m_busy;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pwm  = 0;
    m_pre  = 0;
    m_pat  = '0;
    m_led  = 6'h3f;
    m_busy = 1'b0;
    for (int i = 0; i < 6; i++) m_lvl[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit step_now;
    int tgt;
    if (!RESETn) begin
      model_reset();
    end else begin
      step_now = (m_pre == FSC - 1);
      if (!i_en) begin
        for (int i = 0; i < 6; i++) m_lvl[i] = 0;
        m_pre  = 0;
        m_led  = 6'h3f;
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
          tgt      = m_pat[i] ? MAXV : 0;
          m_led[i] = !((m_lvl[i] == MAXV) || (m_lvl[i] > m_pwm));
          if (m_lvl[i] != tgt) m_busy = 1'b1;
          if (step_now && m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
          else if (step_now && m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
        end
        m_pre = step_now ? 0 : m_pre + 1;
      end
      m_pwm = (m_pwm + 1) % PERIOD;
      m_pat = i_pattern;
    end
    sb.push_back(exp_t'({m_led, m_busy}));
  endtask

  // One clock: model follows the edge, DUT is compared at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check("led", {2'b00, o_led}, {2'b00, e.led});
      check("busy", {7'd0, o_busy}, {7'd0, e.busy});
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    ticks(2);
    while (o_busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, {7'd0, o_busy}, 8'd0);
  endtask

  initial begin
    int   lows;
    logic others_dark;

    model_reset();

    // Reset asserted asynchronously: outputs dark and idle at once.
    #2;
    RESETn = 1'b0;
    rst2_n = 1'b0;
    #1;
    check("rst_led", {2'b00, o_led}, 8'h3f);
    check("rst_busy", {7'd0, o_busy}, 8'd0);
    check("rst2_led", {2'b00, o_led2}, 8'h3f);

    @(negedge CLK);
    RESETn    = 1'b1;
    rst2_n    = 1'b1;
    i_en      = 1'b1;
    i_pattern = 6'h00;
    pat2      = 6'h01;

    // Slow instance reaches level 8 after 8000 clocks and holds it for 1000.
    ticks(8500);
    check("idle_led", {2'b00, o_led}, 8'h3f);
    check("idle_busy", {7'd0, o_busy}, 8'd0);
    lows        = 0;
    others_dark = 1'b1;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      if (!o_led2[0]) lows++;
      others_dark = others_dark & (&o_led2[5:1]);
    end
    check("duty8", 8'(lows), 8'd8);
    check("duty_others", {7'd0, others_dark}, 8'd1);

    // Rise of LED0.
    i_pattern = 6'h01;
    ticks(2);
    check("busy_rise", {7'd0, o_busy}, 8'd1);
    wait_idle(80, "rise_done");
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      check("led0_full", {2'b00, o_led}, 8'h3e);
    end

    // Reverse LED2 from level 6.
    i_pattern = 6'h05;
    for (int k = 0; k < 60 && m_lvl[2] != 6; k++) tick();
    i_pattern = 6'h01;
    wait_idle(60, "rev_done");
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      check("led2_dark", {2'b00, o_led}, 8'h3e);
    end

    // Multi-LED lockstep swap.
    i_pattern = 6'h2a;
    wait_idle(80, "multi_a_done");
    check("multi_a_led", {2'b00, o_led}, 8'h15);
    i_pattern = 6'h15;
    ticks(2);
    check("multi_b_busy", {7'd0, o_busy}, 8'd1);
    wait_idle(80, "multi_b_done");
    check("multi_b_led", {2'b00, o_led}, 8'h2a);

    // Enable drop with all LEDs at full, then restart.
    i_pattern = 6'h3f;
    wait_idle(80, "all_on_done");
    check("all_on_led", {2'b00, o_led}, 8'h00);
    i_en = 1'b0;
    tick();
    check("dis_led", {2'b00, o_led}, 8'h3f);
    check("dis_busy", {7'd0, o_busy}, 8'd0);
    ticks(5);
    check("dis_hold_led", {2'b00, o_led}, 8'h3f);
    i_en = 1'b1;
    tick();
    check("en_busy", {7'd0, o_busy}, 8'd1);
    wait_idle(80, "restart_done");

    // Reset in the middle of a fall.
    i_pattern = 6'h00;
    ticks(10);
    #3;
    RESETn = 1'b0;
    model_reset();
    #1;
    check("midrst_led", {2'b00, o_led}, 8'h3f);
    check("midrst_busy", {7'd0, o_busy}, 8'd0);
    ticks(3);
    RESETn = 1'b1;
    ticks(20);
    check("post_rst_led", {2'b00, o_led}, 8'h3f);
    check("post_rst_busy", {7'd0, o_busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
